divider_n_restoring: RTL and testbench

//  Parametrised sequential restoring divider: WIDTH-bit unsigned Xin / Yin -> Quotient, Remainder.
//  One quotient bit per clock; Start/Ack handshake with one-hot state outputs (Qi, Qc, Qd) for LEDs.

---
 rtl/divider_pkg.sv | 11 +
 rtl/div_restore_step.sv | 24 ++
 rtl/divider_n_restoring.sv | 147 ++++++++++++++
 tb/tb_divider_n_restoring.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared state encodings for the restoring divider. The one-hot values match the
// PicoBlaze status-port bit map {Qd,Qc,Qi}.
package divider_pkg;

    typedef enum logic [2:0] {
        ST_INI     = 3'b001,
        ST_COMPUTE = 3'b010,
        ST_DONE    = 3'b100
    } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: trial subtract of Y from the shifted partial remainder.
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   R_shifted,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R_next,
    output logic             q_bit
);

    logic [WIDTH:0] diff_s;

    // The compare is done at WIDTH+1 bits, so no divisor value can overflow the trial subtract
    always_comb begin
        diff_s = R_shifted - {1'b0, Y};
        q_bit  = (R_shifted >= {1'b0, Y});
        if (q_bit) begin
            R_next = diff_s[WIDTH-1:0];
        end else begin
            R_next = R_shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/divider_n_restoring.sv
// Sequential restoring divider with Start/Ack handshake, one quotient bit per clock.
// Optional DIVIDER_EARLY_EXIT_EN: finish at once when the dividend is below the divisor.
module divider_n_restoring
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Done,
    output logic             Qi,
    output logic             Qc,
    output logic             Qd,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] x_r, y_r, r_r, q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dbz_r;
    logic [WIDTH:0]   r_shift_s;
    logic [WIDTH-1:0] r_next_s;
    logic             q_bit_s;
    logic             last_s;
    logic             yzero_s;
    logic             early_s;

    assign r_shift_s = {r_r, x_r[WIDTH-1]};
    assign last_s    = (cnt_r == CNT_W'(WIDTH - 1));
    assign yzero_s   = (Yin == {WIDTH{1'b0}});

`ifdef DIVIDER_EARLY_EXIT_EN
    assign early_s = (Xin < Yin);
`else
    assign early_s = 1'b0;
`endif

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .R_shifted (r_shift_s),
        .Y         (y_r),
        .R_next    (r_next_s),
        .q_bit     (q_bit_s)
    );

    // Next-state logic for the INI / COMPUTE / DONE handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INI: begin
                if (Start) begin
                    if (yzero_s || early_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_COMPUTE;
                    end
                end else begin
                    state_next_s = ST_INI;
                end
            end
            ST_COMPUTE: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    state_next_s = ST_INI;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_INI;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_INI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch and shift/subtract datapath; results hold outside COMPUTE
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_r   <= {WIDTH{1'b0}};
            y_r   <= {WIDTH{1'b0}};
            r_r   <= {WIDTH{1'b0}};
            q_r   <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            dbz_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INI: begin
                    if (Start) begin
                        x_r   <= Xin;
                        y_r   <= Yin;
                        cnt_r <= {CNT_W{1'b0}};
                        if (yzero_s) begin
                            q_r   <= {WIDTH{1'b1}};
                            r_r   <= Xin;
                            dbz_r <= 1'b1;
                        end else if (early_s) begin
                            q_r   <= {WIDTH{1'b0}};
                            r_r   <= Xin;
                            dbz_r <= 1'b0;
                        end else begin
                            q_r   <= {WIDTH{1'b0}};
                            r_r   <= {WIDTH{1'b0}};
                            dbz_r <= 1'b0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    x_r   <= {x_r[WIDTH-2:0], 1'b0};
                    r_r   <= r_next_s;
                    q_r   <= {q_r[WIDTH-2:0], q_bit_s};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                    x_r <= x_r;
                end
            endcase
        end
    end

    assign Quotient  = q_r;
    assign Remainder = r_r;
    assign DivByZero = dbz_r;
    assign Qi        = (state_r == ST_INI);
    assign Qc        = (state_r == ST_COMPUTE);
    assign Qd        = (state_r == ST_DONE);
    assign Done      = Qd;

endmodule

// File: tb/tb_divider_n_restoring.sv
// Scoreboard bench for divider_n_restoring at WIDTH=8 and WIDTH=16.
module tb_divider_n_restoring;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, ack8, start16, ack16;
    logic [7:0]  x8, y8, q8, r8;
    logic [15:0] x16, y16, q16, r16;
    logic        done8, qi8, qc8, qd8, dbz8;
    logic        done16, qi16, qc16, qd16, dbz16;

    always #5 clk = ~clk;

    divider_n_restoring #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .Ack(ack8), .Xin(x8), .Yin(y8),
        .Quotient(q8), .Remainder(r8), .Done(done8), .Qi(qi8), .Qc(qc8), .Qd(qd8),
        .DivByZero(dbz8)
    );

    divider_n_restoring #(.WIDTH(16)) u_dut16 (
        .Clk(clk), .Reset(rst), .Start(start16), .Ack(ack16), .Xin(x16), .Yin(y16),
        .Quotient(q16), .Remainder(r16), .Done(done16), .Qi(qi16), .Qc(qc16), .Qd(qd16),
        .DivByZero(dbz16)
    );

`ifdef DIVIDER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        int          w;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model; latency counts clock edges from the Start-sampling edge to Done=1
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [31:0] mask;
        mask = (w == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
        e.w  = w;
        if (y == 32'd0) begin
            e.q = mask; e.r = x; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = x / y; e.r = x % y; e.dbz = 1'b0;
            e.lat = (EARLY && (x < y)) ? 1 : w + 1;
        end
        return e;
    endfunction

    task automatic set_ops(input int w, input logic [31:0] x, input logic [31:0] y);
        if (w == 8) begin
            x8 = x[7:0]; y8 = y[7:0];
        end else begin
            x16 = x[15:0]; y16 = y[15:0];
        end
    endtask

    task automatic set_ctl(input int w, input logic s, input logic a);
        if (w == 8) begin
            start8 = s; ack8 = a;
        end else begin
            start16 = s; ack16 = a;
        end
    endtask

    function automatic logic [2:0] obs_state(input int w);
        return (w == 8) ? {qd8, qc8, qi8} : {qd16, qc16, qi16};
    endfunction

    function automatic logic obs_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [31:0] obs_q(input int w);
        return (w == 8) ? {24'd0, q8} : {16'd0, q16};
    endfunction

    function automatic logic [31:0] obs_r(input int w);
        return (w == 8) ? {24'd0, r8} : {16'd0, r16};
    endfunction

    function automatic logic obs_dbz(input int w);
        return (w == 8) ? dbz8 : dbz16;
    endfunction

    // Wait (bounded) for Done, then pop and compare the scoreboard entry
    task automatic wait_check(input int w, input int edges0);
        int   cycles;
        exp_t e;
        cycles = edges0;
        while (!obs_done(w) && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        e = sb.pop_front();
        check("done_seen", {31'd0, obs_done(w)}, 32'd1);
        check("state_done", {29'd0, obs_state(w)}, 32'd4);
        check("quotient", obs_q(w), e.q);
        check("remainder", obs_r(w), e.r);
        check("divbyzero", {31'd0, obs_dbz(w)}, {31'd0, e.dbz});
        check("latency", cycles, e.lat);
    endtask

    task automatic do_ack(input int w);
        @(negedge clk); set_ctl(w, 1'b0, 1'b1);
        @(posedge clk); #1; set_ctl(w, 1'b0, 1'b0);
        check("ack_to_ini", {29'd0, obs_state(w)}, 32'd1);
    endtask

    task automatic launch(input int w, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        set_ops(w, x, y);
        set_ctl(w, 1'b1, 1'b0);
        sb.push_back(model(w, x, y));
        @(posedge clk); #1;
        set_ctl(w, 1'b0, 1'b0);
        set_ops(w, $urandom, $urandom);
        wait_check(w, 1);
        do_ack(w);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; ack8 = 1'b0; start16 = 1'b0; ack16 = 1'b0;
        x8 = 8'd0; y8 = 8'd0; x16 = 16'd0; y16 = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state8", {29'd0, obs_state(8)}, 32'd1);
        check("rst_q8", obs_q(8), 32'd0);
        check("rst_r8", obs_r(8), 32'd0);
        check("rst_dbz8", {31'd0, obs_dbz(8)}, 32'd0);
        check("rst_state16", {29'd0, obs_state(16)}, 32'd1);
        check("rst_done16", {31'd0, obs_done(16)}, 32'd0);
        rst = 1'b0;

        launch(8, 32'd200, 32'd7);
        launch(8, 32'h5A, 32'd0);
        launch(16, 32'hFFFF, 32'h0001);
        launch(16, 32'hFFFF, 32'hFFFF);
        launch(8, 32'd3, 32'd9);
        launch(16, 32'd3, 32'd9);
        launch(8, 32'd255, 32'd255);
        launch(8, 32'd0, 32'd5);
        launch(8, 32'd255, 32'd1);
        launch(16, 32'd0, 32'd0);

        // Reset during the 4th COMPUTE cycle aborts the operation
        @(negedge clk);
        set_ops(8, 32'd200, 32'd7);
        set_ctl(8, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_ctl(8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("abort_state", {29'd0, obs_state(8)}, 32'd1);
        check("abort_q", obs_q(8), 32'd0);
        check("abort_r", obs_r(8), 32'd0);
        launch(8, 32'd201, 32'd10);

        // Start and Ack together in DONE return to INI only; held Start relaunches next
        @(negedge clk);
        set_ops(8, 32'd50, 32'd6);
        set_ctl(8, 1'b1, 1'b0);
        sb.push_back(model(8, 32'd50, 32'd6));
        @(posedge clk); #1;
        set_ctl(8, 1'b0, 1'b0);
        wait_check(8, 1);
        @(negedge clk);
        set_ops(8, 32'd77, 32'd5);
        set_ctl(8, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("start_ack_ini", {29'd0, obs_state(8)}, 32'd1);
        set_ctl(8, 1'b1, 1'b0);
        sb.push_back(model(8, 32'd77, 32'd5));
        @(posedge clk); #1;
        check("held_start_compute", {29'd0, obs_state(8)}, 32'd2);
        set_ctl(8, 1'b0, 1'b0);
        wait_check(8, 1);
        do_ack(8);

        for (int i = 0; i < 2000; i++) begin
            launch(8, $urandom_range(0, 255),
                   ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom_range(0, 255));
        end
        for (int i = 0; i < 2000; i++) begin
            launch(16, $urandom_range(0, 65535),
                   ($urandom_range(0, 15) == 0) ? 32'd0 :
                   (($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
